// File: rtl/sff_serial_tx.sv
// sff_serial_tx: framed, LSB-first bit-serial transmitter with a valid/ready
// word input. Frame = start (0), WIDTH data bits, optional even parity, stop (1).
// The line register txd is preset to the idle/mark level on reset; state and
// counters clear to zero.
module sff_serial_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             txd,
   output logic             busy,
   output logic             done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [IW-1:0]    idx, idx_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] shreg_sh;
   logic             par_bit, par_nxt;
   logic             txd_q, txd_nxt;
   logic             bit_end;

   assign bit_end  = (cnt == CNT_LAST);
   assign shreg_sh = shreg >> 1;

   // Outputs decoded from the current state; reset forces IDLE so these clear at once.
   assign in_ready = (state == S_IDLE) && !rst;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_STOP) && bit_end;
   assign txd      = txd_q;

   // Register all frame state; txd presets to mark (1), everything else clears.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shreg   <= shreg_nxt;
         par_bit <= par_nxt;
         txd_q   <= txd_nxt;
      end
   end

   // Next-state logic; txd_nxt is the line level for the state being entered,
   // so the registered txd lines up exactly with the registered state.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      txd_nxt   = txd_q;

      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            txd_nxt = 1'b1;
            if (in_valid && in_ready) begin
               state_nxt = S_START;
               shreg_nxt = in_data;
               par_nxt   = ^in_data;
               txd_nxt   = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = S_DATA;
               txd_nxt   = shreg[0];
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (idx == IDX_LAST) begin
                  if (PARITY != 0) begin
                     state_nxt = S_PARITY;
                     txd_nxt   = par_bit;
                  end else begin
                     state_nxt = S_STOP;
                     txd_nxt   = 1'b1;
                  end
               end else begin
                  idx_nxt   = idx + 1'b1;
                  shreg_nxt = shreg_sh;
                  txd_nxt   = shreg_sh[0];
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               state_nxt = S_STOP;
               txd_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_STOP: begin
            txd_nxt = 1'b1;
            if (bit_end) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            txd_nxt   = 1'b1;
         end
      endcase
   end

endmodule
